// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DefaultXlen = 32;
  localparam int unsigned DefaultAw   = 5;

  // Grant encoding; also the encoding of the "granted last" register.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef struct packed {
    logic [DefaultAw-1:0]   rd;
    logic [DefaultXlen-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back sources, freeze control and regfile write pins of the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = regfile_wb_arbiter_pkg::DefaultXlen,
  parameter int unsigned AW   = regfile_wb_arbiter_pkg::DefaultAw
);

  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_wdata;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_wdata;
  logic            freeze;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [2**AW-1:0] pend_mask;

  // Pipeline side: drives the write requests and freeze.
  modport master (
    output a_valid, a_rd, a_wdata, b_valid, b_rd, b_wdata, freeze,
    input  a_ready, b_ready, rf_we, rf_rd, rf_wdata, pend_mask
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_rd, a_wdata, b_valid, b_rd, b_wdata, freeze,
    output a_ready, b_ready, rf_we, rf_rd, rf_wdata, pend_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant; the "granted last" bit advances only on accept.
module regfile_wb_arbiter_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic accept,
  output logic grant
);

  logic last_q, last_d;

  // Sole requester wins; a tie goes to the source not granted last.
  always_comb begin
    grant = ~last_q;
    if (a_valid && !b_valid) begin
      grant = GRANT_A;
    end else if (b_valid && !a_valid) begin
      grant = GRANT_B;
    end
  end

  // Remember the winner of each accepted write.
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant;
    end
  end

  // Reset to "B last" so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= GRANT_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) write-backs onto the single regfile write
// port through a one-entry output stage; exports a pending-write mask.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = DefaultXlen,
  parameter int unsigned AW   = DefaultAw
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wdata;
  } stage_t;

  logic   ovalid_q, ovalid_d;
  stage_t stage_q, stage_d;
  stage_t req;
  logic   grant, drain, can_load, a_acc, b_acc, accept;

  regfile_wb_arbiter_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (bus.a_valid),
    .b_valid (bus.b_valid),
    .accept  (accept),
    .grant   (grant)
  );

  // Handshakes and regfile pins; everything is quiet while reset is asserted
  // so a held write cannot reach the regfile in the reset cycle.
  always_comb begin
    drain       = rst_n & ovalid_q & ~bus.freeze;
    can_load    = rst_n & (~ovalid_q | drain);
    a_acc       = can_load & bus.a_valid & (grant == GRANT_A);
    b_acc       = can_load & bus.b_valid & (grant == GRANT_B);
    accept      = a_acc | b_acc;
    bus.a_ready = a_acc;
    bus.b_ready = b_acc;
    bus.rf_we   = drain;
    bus.rf_rd   = stage_q.rd;
    bus.rf_wdata = stage_q.wdata;
    bus.pend_mask = '0;
    if (ovalid_q) begin
      bus.pend_mask[stage_q.rd] = 1'b1;
    end
  end

  // Select the granted request.
  always_comb begin
    req.rd    = (grant == GRANT_A) ? bus.a_rd : bus.b_rd;
    req.wdata = (grant == GRANT_A) ? bus.a_wdata : bus.b_wdata;
  end

  // Output stage: empties on drain, loads on accept unless the target is x0.
  always_comb begin
    ovalid_d = ovalid_q;
    stage_d  = stage_q;
    if (drain) begin
      ovalid_d = 1'b0;
    end
    if (accept && (req.rd != '0)) begin
      ovalid_d = 1'b1;
      stage_d  = req;
    end
  end

  // Output stage register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovalid_q <= 1'b0;
      stage_q  <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      stage_q  <= stage_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  wb_req_t exp_q[$];

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    wb_req_t e;
    e.rd    = rd;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Every regfile write must match the oldest expected write.
  always @(negedge clk) begin : mon
    wb_req_t e;
    if (bus.rf_we === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write: got rd=%0d data=%0h expected none",
               bus.rf_rd, bus.rf_wdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_rd", 64'(bus.rf_rd), 64'(e.rd));
        check("wr_data", 64'(bus.rf_wdata), 64'(e.wdata));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd5;
    bus.a_wdata = 32'hDEADBEEF;
    bus.b_valid = 1'b0;
    bus.b_rd    = '0;
    bus.b_wdata = '0;
    bus.freeze  = 1'b0;

    // Reset with A requesting.
    tick();
    check("rst_we", 64'(bus.rf_we), 64'd0);
    check("rst_pend", 64'(bus.pend_mask), 64'd0);
    check("rst_a_ready", 64'(bus.a_ready), 64'd0);
    check("rst_rd", 64'(bus.rf_rd), 64'd0);
    check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_a_ready", 64'(bus.a_ready), 64'd1);
    check("rel_b_ready", 64'(bus.b_ready), 64'd0);
    push(5'd5, 32'hDEADBEEF);

    // Single write reaches the regfile one cycle later.
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("single_we", 64'(bus.rf_we), 64'd1);
    check("single_rd", 64'(bus.rf_rd), 64'd5);
    check("single_pend", 64'(bus.pend_mask), 64'h20);

    // One B write so that A wins the following tie.
    bus.b_valid = 1'b1;
    bus.b_rd    = 5'd6;
    bus.b_wdata = 32'h66;
    #1;
    check("b6_ready", 64'(bus.b_ready), 64'd1);
    push(5'd6, 32'h66);
    tick();

    // Contention: alternating grants, one write per cycle, in order.
    for (int i = 1; i <= 4; i++) begin
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      bus.a_rd    = 5'(i);
      bus.b_rd    = 5'(i);
      bus.a_wdata = 32'hA000_0000 + 32'(i);
      bus.b_wdata = 32'hB000_0000 + 32'(i);
      #1;
      check("cont_a_ready", 64'(bus.a_ready), 64'(i % 2));
      check("cont_b_ready", 64'(bus.b_ready), 64'((i + 1) % 2));
      check("cont_we", 64'(bus.rf_we), 64'd1);
      check("cont_rf_rd", 64'(bus.rf_rd), (i == 1) ? 64'd6 : 64'(i - 1));
      if (i % 2 == 1) push(5'(i), 32'hA000_0000 + 32'(i));
      else            push(5'(i), 32'hB000_0000 + 32'(i));
      tick();
    end

    // x0 write from B: accepted, never written.
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1;
    bus.b_rd    = 5'd0;
    bus.b_wdata = 32'h1234;
    #1;
    check("x0_b_ready", 64'(bus.b_ready), 64'd1);
    tick();
    bus.b_valid = 1'b0;
    #1;
    check("x0_no_we", 64'(bus.rf_we), 64'd0);
    check("x0_pend", 64'(bus.pend_mask), 64'd0);
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd10;
    bus.a_wdata = 32'hA10;
    bus.b_valid = 1'b1;
    bus.b_rd    = 5'd11;
    bus.b_wdata = 32'hB11;
    #1;
    check("x0_tie_a", 64'(bus.a_ready), 64'd1);
    check("x0_tie_b", 64'(bus.b_ready), 64'd0);
    push(5'd10, 32'hA10);
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("b11_ready", 64'(bus.b_ready), 64'd1);
    push(5'd11, 32'hB11);
    tick();
    bus.b_valid = 1'b0;
    #1;
    check("b11_rd", 64'(bus.rf_rd), 64'd11);
    tick();

    // Freeze with rd=7 held in the stage.
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd7;
    bus.a_wdata = 32'h77;
    #1;
    check("a7_ready", 64'(bus.a_ready), 64'd1);
    push(5'd7, 32'h77);
    tick();
    bus.freeze  = 1'b1;
    bus.a_rd    = 5'd8;
    bus.a_wdata = 32'h88;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("frz_we", 64'(bus.rf_we), 64'd0);
      check("frz_a_ready", 64'(bus.a_ready), 64'd0);
      check("frz_pend", 64'(bus.pend_mask), 64'h80);
      check("frz_rd", 64'(bus.rf_rd), 64'd7);
      tick();
    end
    bus.freeze = 1'b0;
    #1;
    check("unfrz_we", 64'(bus.rf_we), 64'd1);
    check("unfrz_rd", 64'(bus.rf_rd), 64'd7);
    check("unfrz_a_ready", 64'(bus.a_ready), 64'd1);
    push(5'd8, 32'h88);
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("a8_rd", 64'(bus.rf_rd), 64'd8);
    tick();

    // Freeze with an empty stage: one accept, then hold.
    bus.freeze  = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd12;
    bus.a_wdata = 32'hCC;
    #1;
    check("frz0_a_ready", 64'(bus.a_ready), 64'd1);
    check("frz0_we", 64'(bus.rf_we), 64'd0);
    push(5'd12, 32'hCC);
    tick();
    bus.a_rd    = 5'd15;
    bus.a_wdata = 32'hFF;
    #1;
    check("frz1_a_ready", 64'(bus.a_ready), 64'd0);
    check("frz1_we", 64'(bus.rf_we), 64'd0);
    check("frz1_pend", 64'(bus.pend_mask), 64'h1000);
    tick();
    bus.freeze  = 1'b0;
    bus.a_valid = 1'b0;
    #1;
    check("frz2_we", 64'(bus.rf_we), 64'd1);
    check("frz2_rd", 64'(bus.rf_rd), 64'd12);
    tick();

    // Mid-operation reset discards rd=9 and restores A priority.
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd9;
    bus.a_wdata = 32'h99;
    #1;
    check("a9_ready", 64'(bus.a_ready), 64'd1);
    tick();
    bus.a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_we", 64'(bus.rf_we), 64'd0);
    tick();
    check("midrst_pend", 64'(bus.pend_mask), 64'd0);
    check("midrst_rd", 64'(bus.rf_rd), 64'd0);
    rst_n = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd13;
    bus.a_wdata = 32'hD13;
    bus.b_valid = 1'b1;
    bus.b_rd    = 5'd14;
    bus.b_wdata = 32'hE14;
    #1;
    check("postrst_a", 64'(bus.a_ready), 64'd1);
    check("postrst_b", 64'(bus.b_ready), 64'd0);
    push(5'd13, 32'hD13);
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("b14_ready", 64'(bus.b_ready), 64'd1);
    push(5'd14, 32'hE14);
    tick();
    bus.b_valid = 1'b0;
    repeat (3) tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
